// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors, width helpers and default margins.
// Used by both sync_fifo and async_fifo.
package fifo_pkg;

   localparam string FIFO_MODE_FWFT = "TRUE";
   localparam string FIFO_MODE_REG  = "FALSE";

   localparam int FIFO_DEF_NF_MRGN = 4;
   localparam int FIFO_DEF_NE_MRGN = 4;

   // Width needed to hold a value in 0..depth (counts and margins).
   function automatic int fifo_cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width needed to address 0..depth-1, never less than one bit.
   function automatic int fifo_addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port FIFO storage: synchronous write, asynchronous read, no reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int DEPTH = 16,
   parameter int AW    = fifo_addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [DSIZE-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [DSIZE-1:0] o_rdata
);

   logic [DSIZE-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth with FWFT or registered read, programmable
// near-full/near-empty margins, occupancy count and overflow/underflow pulses.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int    DSIZE       = 8,
   parameter int    DEPTH       = 16,
   parameter string FALLTHROUGH = FIFO_MODE_FWFT,
   parameter int    CSIZE       = fifo_cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wen,
   input  logic [DSIZE-1:0] wdata,
   input  logic             ren,
   input  logic [CSIZE-1:0] near_full_mrgn,
   input  logic [CSIZE-1:0] near_empty_mrgn,
   output logic [DSIZE-1:0] rdata,
   output logic [CSIZE-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             near_full,
   output logic             near_empty,
   output logic             over_flow,
   output logic             under_flow
);

   localparam int             AW      = fifo_addr_width(DEPTH);
   localparam logic [CSIZE:0] P_DEPTH = (CSIZE+1)'(DEPTH);
   localparam logic [AW-1:0]  P_LAST  = AW'(DEPTH - 1);
   localparam bit             P_FWFT  = (FALLTHROUGH == FIFO_MODE_FWFT);

   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CSIZE-1:0] r_count;
   logic             r_full, r_empty, r_near_full, r_near_empty;
   logic             r_over_flow, r_under_flow;

   logic             w_wacc, w_racc, w_mem_we;
   logic [AW-1:0]    w_wptr_inc, w_rptr_inc;
   logic [CSIZE:0]   w_count_next, w_nf_mrgn, w_nf_thresh;
   logic             w_full_next, w_empty_next;
   logic [DSIZE-1:0] w_mem_rdata;

   assign w_wacc   = wen && !r_full;
   assign w_racc   = ren && !r_empty;
   assign w_mem_we = w_wacc && !clr && !rst;

   // Non-power-of-two depth: wrap with an explicit compare rather than masking.
   assign w_wptr_inc = (r_wptr == P_LAST) ? '0 : r_wptr + 1'b1;
   assign w_rptr_inc = (r_rptr == P_LAST) ? '0 : r_rptr + 1'b1;

   assign w_count_next = {1'b0, r_count} + {{CSIZE{1'b0}}, w_wacc}
                                         - {{CSIZE{1'b0}}, w_racc};
   assign w_full_next  = (w_count_next == P_DEPTH);
   assign w_empty_next = (w_count_next == '0);

   // Near-full threshold saturates at zero when the margin exceeds the depth.
   assign w_nf_mrgn   = {1'b0, near_full_mrgn};
   assign w_nf_thresh = (w_nf_mrgn > P_DEPTH) ? '0 : P_DEPTH - w_nf_mrgn;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_near_full  <= 1'b0;
         r_near_empty <= 1'b0;
         r_over_flow  <= 1'b0;
         r_under_flow <= 1'b0;
      end else begin
         if (w_wacc) begin
            r_wptr <= w_wptr_inc;
         end
         if (w_racc) begin
            r_rptr <= w_rptr_inc;
         end
         r_count      <= w_count_next[CSIZE-1:0];
         r_full       <= w_full_next;
         r_empty      <= w_empty_next;
         r_near_full  <= !w_full_next && (w_count_next >= w_nf_thresh);
         r_near_empty <= !w_empty_next && (w_count_next <= {1'b0, near_empty_mrgn});
         r_over_flow  <= wen && r_full;
         r_under_flow <= ren && r_empty;
      end
   end

   fifo_mem #(
      .DSIZE (DSIZE),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wptr),
      .i_wdata (wdata),
      .i_raddr (r_rptr),
      .o_rdata (w_mem_rdata)
   );

   generate
      if (P_FWFT) begin : g_fwft
         assign rdata = r_empty ? '0 : w_mem_rdata;
      end else begin : g_reg
         logic [DSIZE-1:0] r_rdata;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rdata <= '0;
            end else if (w_racc && !clr) begin
               r_rdata <= w_mem_rdata;
            end
         end
         assign rdata = r_rdata;
      end
   endgenerate

   assign count      = r_count;
   assign full       = r_full;
   assign empty      = r_empty;
   assign near_full  = r_near_full;
   assign near_empty = r_near_empty;
   assign over_flow  = r_over_flow;
   assign under_flow = r_under_flow;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a fall-through and a registered-read instance (DEPTH=12) share
// stimulus; a queue scoreboard supplies read data and a reference count drives the flags.
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int DP = 12;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          wen = 1'b0;
   logic          ren = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [CW-1:0] nf_mrgn = 4'd4;
   logic [CW-1:0] ne_mrgn = 4'd4;

   logic [DW-1:0] f_rdata, g_rdata;
   logic [CW-1:0] f_count, g_count;
   logic f_full, f_empty, f_nf, f_ne, f_ovf, f_unf;
   logic g_full, g_empty, g_nf, g_ne, g_ovf, g_unf;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_regrd = '0;
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo #(.DSIZE(DW), .DEPTH(DP), .FALLTHROUGH("TRUE")) u_fwft (
      .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
      .near_full_mrgn(nf_mrgn), .near_empty_mrgn(ne_mrgn),
      .rdata(f_rdata), .count(f_count), .full(f_full), .empty(f_empty),
      .near_full(f_nf), .near_empty(f_ne), .over_flow(f_ovf), .under_flow(f_unf)
   );

   sync_fifo #(.DSIZE(DW), .DEPTH(DP), .FALLTHROUGH("FALSE")) u_reg (
      .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
      .near_full_mrgn(nf_mrgn), .near_empty_mrgn(ne_mrgn),
      .rdata(g_rdata), .count(g_count), .full(g_full), .empty(g_empty),
      .near_full(g_nf), .near_empty(g_ne), .over_flow(g_ovf), .under_flow(g_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_nf(input int c);
      int t;
      t = DP - int'(nf_mrgn);
      if (t < 0) t = 0;
      return (c != DP) && (c >= t);
   endfunction

   function automatic bit exp_ne(input int c);
      return (c != 0) && (c <= int'(ne_mrgn));
   endfunction

   task automatic check_all(input string ph);
      int c;
      logic [DW-1:0] head;
      c = m_q.size();
      head = (c == 0) ? '0 : m_q[0];
      $display("%s: count=%0d full=%0b empty=%0b nf=%0b ne=%0b ovf=%0b unf=%0b fwft_rd=%0h reg_rd=%0h",
               ph, f_count, f_full, f_empty, f_nf, f_ne, f_ovf, f_unf, f_rdata, g_rdata);
      chk({ph, ".count"},      32'(f_count), 32'(c));
      chk({ph, ".full"},       32'(f_full),  32'(c == DP));
      chk({ph, ".empty"},      32'(f_empty), 32'(c == 0));
      chk({ph, ".near_full"},  32'(f_nf),    32'(exp_nf(c)));
      chk({ph, ".near_empty"}, 32'(f_ne),    32'(exp_ne(c)));
      chk({ph, ".over_flow"},  32'(f_ovf),   32'(m_ovf));
      chk({ph, ".under_flow"}, 32'(f_unf),   32'(m_unf));
      chk({ph, ".fwft_rdata"}, 32'(f_rdata), 32'(head));
      chk({ph, ".reg_status"}, {g_count, g_full, g_empty, g_nf, g_ne, g_ovf, g_unf},
                               {f_count, f_full, f_empty, f_nf, f_ne, f_ovf, f_unf});
      chk({ph, ".reg_count"},  32'(g_count), 32'(c));
      chk({ph, ".reg_rdata"},  32'(g_rdata), 32'(m_regrd));
   endtask

   // One clock of stimulus; model updates with the same edge, then outputs are checked.
   task automatic cycle(input string ph, input bit w, input logic [DW-1:0] d,
                        input bit r, input bit c);
      bit full_b, empty_b, wacc, racc;
      logic [DW-1:0] exp_rd;
      wen = w; wdata = d; ren = r; clr = c;
      full_b  = (m_q.size() == DP);
      empty_b = (m_q.size() == 0);
      wacc = w && !full_b;
      racc = r && !empty_b;
      if (c) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (racc) begin
            exp_rd = m_q.pop_front();
            chk({ph, ".fwft_head"}, 32'(f_rdata), 32'(exp_rd));
            m_regrd = exp_rd;
         end
         if (wacc) m_q.push_back(d);
         m_ovf = w && full_b;
         m_unf = r && empty_b;
      end
      @(posedge clk);
      #1;
      wen = 1'b0; ren = 1'b0; clr = 1'b0;
      check_all(ph);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_regrd = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   initial begin
      int n_wr;
      bit w, r;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all("reset");

      // Underflow from empty
      cycle("underflow", 0, 8'h00, 1, 0);
      cycle("underflow_clear", 0, 8'h00, 0, 0);

      // Margin reconfiguration; first word is 0xA5
      cycle("wr_a5", 1, 8'hA5, 0, 0);
      for (int i = 1; i < 4; i++) cycle("wr_to4", 1, 8'(8'h10 + i), 0, 0);
      ne_mrgn = 4'd6;
      for (int i = 0; i < 2; i++) cycle("wr_to6", 1, 8'(8'h20 + i), 0, 0);
      cycle("wr_to7", 1, 8'h30, 0, 0);
      cycle("wr_to8", 1, 8'h31, 0, 0);
      nf_mrgn = 4'd3;
      cycle("nf_mrgn3", 0, 8'h00, 0, 0);

      // Registered read presents 0xA5 the cycle after the read
      cycle("read_a5", 0, 8'h00, 1, 0);
      chk("reg_rdata_a5", 32'(g_rdata), 32'h0000_00A5);

      // Fill and overflow
      nf_mrgn = 4'd4;
      ne_mrgn = 4'd4;
      while (m_q.size() < DP) cycle("fill", 1, 8'($urandom), 0, 0);
      cycle("overflow", 1, 8'hEE, 0, 0);
      cycle("overflow_clear", 0, 8'h00, 0, 0);

      // Simultaneous corners
      cycle("rw_full", 1, 8'hCC, 1, 0);
      while (m_q.size() > 0) cycle("drain", 0, 8'h00, 1, 0);
      cycle("rw_empty", 1, 8'h5A, 1, 0);

      // Flush wins over write
      cycle("clr_wen", 1, 8'h77, 0, 1);

      // Margin extremes: saturated near-full threshold, zero near-empty margin
      nf_mrgn = 4'd15;
      cycle("nf_saturate", 0, 8'h00, 0, 0);
      nf_mrgn = 4'd4;
      ne_mrgn = 4'd0;
      cycle("ne_mrgn0", 1, 8'h42, 0, 0);
      ne_mrgn = 4'd4;
      cycle("drain1", 0, 8'h00, 1, 0);

      // Random stream of 40 words with wrap-around
      n_wr = 0;
      for (int i = 0; i < 400 && n_wr < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (w && m_q.size() < DP) n_wr++;
         cycle("stream", w, 8'($urandom), r, 0);
      end
      chk("stream_budget", 32'(n_wr >= 40), 32'd1);
      while (m_q.size() > 0) cycle("stream_drain", 0, 8'h00, 1, 0);

      // Reset mid-stream
      for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 8'(8'h60 + i), 0, 0);
      cycle("pre_rst_rd", 0, 8'h00, 1, 0);
      rst = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 8'h99;
      @(posedge clk);
      #1;
      rst = 1'b0; wen = 1'b0; ren = 1'b0;
      model_reset();
      check_all("rst_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
